// File: rtl/hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_pkg
// Shared pipeline constants for the hazard unit and the ID/EX register.
//   stall_t       : 2-bit ID/EX stall code (NONE / BUBBLE / FLUSH; 11 unused)
//   ST_*          : hazard FSM state encoding
//   hz_ctrl_t     : bundle of the four per-cycle pipeline control outputs
//   REG_ZERO      : hardwired-zero register index (never a hazard source)
// -----------------------------------------------------------------------------
package hazard_unit_pkg;

  typedef logic [1:0] stall_t;

  localparam stall_t STALL_NONE   = 2'b00;
  localparam stall_t STALL_BUBBLE = 2'b01;
  localparam stall_t STALL_FLUSH  = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUBBLE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  localparam logic [2:0] REG_ZERO = 3'd0;

  typedef struct packed {
    stall_t stall;
    logic   pc_hold;
    logic   ifid_hold;
    logic   ifid_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_QUIET = '{
    stall:      STALL_NONE,
    pc_hold:    1'b0,
    ifid_hold:  1'b0,
    ifid_flush: 1'b0
  };

endpackage

// File: rtl/hazard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_if
// Bundles the pipeline-facing signals of the hazard unit.
//   Inputs to the unit : id_rs, id_rt, id_uses_rt, ex_load, ex_rd, branch_taken
//   Outputs of the unit: stall, pc_hold, ifid_hold, ifid_flush,
//                        bubble_cnt, flush_cnt
//   master modport: the pipeline side (drives stage info, consumes controls)
//   slave  modport: the hazard unit itself
// -----------------------------------------------------------------------------
interface hazard_unit_if import hazard_unit_pkg::*; ();

  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       id_uses_rt;
  logic       ex_load;
  logic [2:0] ex_rd;
  logic       branch_taken;

  stall_t     stall;
  logic       pc_hold;
  logic       ifid_hold;
  logic       ifid_flush;
  logic [7:0] bubble_cnt;
  logic [7:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_load, ex_rd, branch_taken,
    input  stall, pc_hold, ifid_hold, ifid_flush, bubble_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_load, ex_rd, branch_taken,
    output stall, pc_hold, ifid_hold, ifid_flush, bubble_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_unit_sat_counter8.sv
// -----------------------------------------------------------------------------
// sat_counter8
// 8-bit event counter that sticks at 255 instead of wrapping.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count one event at the next rising edge
//   count : current count
// -----------------------------------------------------------------------------
module sat_counter8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Detects load-use hazards and taken branches for a 5-stage pipeline and
// generates the ID/EX stall code plus PC / IF-ID hold and flush controls.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   hz    : hazard_unit_if.slave (stage info in, pipeline controls and
//           bubble / flush event counters out)
// The controls are combinational from the current state and inputs so that
// ID/EX and the front end act on them at the same edge that moves the FSM.
// -----------------------------------------------------------------------------
module hazard_unit import hazard_unit_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  hazard_unit_if.slave hz
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       load_use;
  hz_ctrl_t   ctrl_fsm;
  hz_ctrl_t   ctrl_out;
  logic [1:0] cnt_inc;
  logic [7:0] cnt_val [2];

  // Register 0 is hardwired, so a load targeting it can never feed anyone.
  always_comb begin
    load_use = hz.ex_load && (hz.ex_rd != REG_ZERO) &&
               ((hz.ex_rd == hz.id_rs) ||
                (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));
  end

  always_comb begin
    state_d  = state_q;
    ctrl_fsm = CTRL_QUIET;
    case (state_q)
      ST_IDLE: begin
        // A taken branch squashes the ID instruction anyway, so any
        // simultaneous load-use hazard on it is irrelevant.
        if (hz.branch_taken) begin
          ctrl_fsm.stall      = STALL_FLUSH;
          ctrl_fsm.ifid_flush = 1'b1;
          state_d             = ST_FLUSH;
        end else if (load_use) begin
          ctrl_fsm.stall     = STALL_BUBBLE;
          ctrl_fsm.pc_hold   = 1'b1;
          ctrl_fsm.ifid_hold = 1'b1;
          state_d            = ST_BUBBLE;
        end
      end
      ST_BUBBLE: begin
        // Load now in MEM, bubble in EX: nothing to detect, nothing can branch.
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        // Second squashed instruction reaches ID/EX this cycle.
        ctrl_fsm.stall = STALL_FLUSH;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controls must drop the moment reset asserts, not at the next edge.
  always_comb begin
    ctrl_out = rst_n ? ctrl_fsm : CTRL_QUIET;
  end

  assign hz.stall      = ctrl_out.stall;
  assign hz.pc_hold    = ctrl_out.pc_hold;
  assign hz.ifid_hold  = ctrl_out.ifid_hold;
  assign hz.ifid_flush = ctrl_out.ifid_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Index 0 counts bubbles, index 1 counts flushes.
  always_comb begin
    cnt_inc[0] = (state_q == ST_IDLE) && (state_d == ST_BUBBLE);
    cnt_inc[1] = (state_q == ST_IDLE) && (state_d == ST_FLUSH);
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter8 u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc[gi]),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  assign hz.bubble_cnt = cnt_val[0];
  assign hz.flush_cnt  = cnt_val[1];

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Scoreboard bench for hazard_unit. Each cycle the stimulus is applied after
// the falling edge, the reference model's expected outputs are queued, and
// the entry is popped and compared against the DUT before the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  typedef struct {
    string      tag;
    logic [1:0] stall;
    logic       pc_hold;
    logic       ifid_hold;
    logic       ifid_flush;
    logic [7:0] bcnt;
    logic [7:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  hazard_unit_if hz ();

  hazard_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;

  // Reference model state: 0 idle, 1 bubble, 2 flush.
  int   m_state = 0;
  int   m_bcnt  = 0;
  int   m_fcnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit m_hazard();
    bit rs_hit, rt_hit;
    rs_hit = (hz.ex_rd == hz.id_rs);
    rt_hit = hz.id_uses_rt && (hz.ex_rd == hz.id_rt);
    return hz.ex_load && (hz.ex_rd != 3'd0) && (rs_hit || rt_hit);
  endfunction

  task automatic m_reset();
    m_state = 0;
    m_bcnt  = 0;
    m_fcnt  = 0;
  endtask

  task automatic push_expect(input string tag);
    exp_t e;
    e.tag        = tag;
    e.stall      = 2'b00;
    e.pc_hold    = 1'b0;
    e.ifid_hold  = 1'b0;
    e.ifid_flush = 1'b0;
    e.bcnt       = 8'(m_bcnt);
    e.fcnt       = 8'(m_fcnt);
    if (rst_n) begin
      if (m_state == 0) begin
        if (hz.branch_taken) begin
          e.stall      = 2'b10;
          e.ifid_flush = 1'b1;
        end else if (m_hazard()) begin
          e.stall     = 2'b01;
          e.pc_hold   = 1'b1;
          e.ifid_hold = 1'b1;
        end
      end else if (m_state == 2) begin
        e.stall = 2'b10;
      end
    end
    sb.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    n_txn++;
    $display("txn %0d %s stall=%b pc_hold=%b ifid_hold=%b ifid_flush=%b bcnt=%0d fcnt=%0d",
             n_txn, e.tag, hz.stall, hz.pc_hold, hz.ifid_hold, hz.ifid_flush,
             hz.bubble_cnt, hz.flush_cnt);
    check({e.tag, ".stall"},      32'(hz.stall),      32'(e.stall));
    check({e.tag, ".pc_hold"},    32'(hz.pc_hold),    32'(e.pc_hold));
    check({e.tag, ".ifid_hold"},  32'(hz.ifid_hold),  32'(e.ifid_hold));
    check({e.tag, ".ifid_flush"}, 32'(hz.ifid_flush), 32'(e.ifid_flush));
    check({e.tag, ".bubble_cnt"}, 32'(hz.bubble_cnt), 32'(e.bcnt));
    check({e.tag, ".flush_cnt"},  32'(hz.flush_cnt),  32'(e.fcnt));
    check({e.tag, ".hold_vs_flush"}, 32'(hz.pc_hold & hz.ifid_flush), 32'd0);
  endtask

  // Model state update at the rising edge, from the inputs held across it.
  task automatic model_step();
    if (!rst_n) begin
      m_reset();
    end else begin
      case (m_state)
        0: begin
          if (hz.branch_taken) begin
            m_state = 2;
            if (m_fcnt < 255) m_fcnt++;
          end else if (m_hazard()) begin
            m_state = 1;
            if (m_bcnt < 255) m_bcnt++;
          end
        end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic drive_cycle(input string tag, input logic rst, input logic bt,
                             input logic ld, input logic [2:0] rd, input logic [2:0] rs,
                             input logic [2:0] rt, input logic ur);
    @(negedge clk);
    rst_n           = rst;
    hz.branch_taken = bt;
    hz.ex_load      = ld;
    hz.ex_rd        = rd;
    hz.id_rs        = rs;
    hz.id_rt        = rt;
    hz.id_uses_rt   = ur;
    if (!rst) m_reset();
    #1 push_expect(tag);
    #1 compare_pop();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input string tag);
    drive_cycle(tag, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
  endtask

  initial begin
    hz.branch_taken = 1'b0;
    hz.ex_load      = 1'b0;
    hz.ex_rd        = 3'd0;
    hz.id_rs        = 3'd0;
    hz.id_rt        = 3'd0;
    hz.id_uses_rt   = 1'b0;

    // Asynchronous reset before any clock edge, with a branch pending.
    #1 rst_n = 1'b0;
    hz.branch_taken = 1'b1;
    m_reset();
    #1 push_expect("rst_async");
    #1 compare_pop();
    drive_cycle("rst_hold", 1'b0, 1'b1, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0);
    idle("rst_release");
    idle("idle");

    // Load-use on rs, then the bubble cycle with the same inputs.
    drive_cycle("lu_rs", 1'b1, 1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0);
    drive_cycle("lu_bubble", 1'b1, 1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0);
    idle("lu_after");

    // Register 0 never hazards, on either operand.
    drive_cycle("r0_rs", 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 1'b1);

    // rt only matters when the instruction reads it.
    drive_cycle("rt_unused", 1'b1, 1'b0, 1'b1, 3'd5, 3'd1, 3'd5, 1'b0);
    drive_cycle("rt_used", 1'b1, 1'b0, 1'b1, 3'd5, 3'd1, 3'd5, 1'b1);
    idle("rt_after");

    // Non-load in EX never hazards.
    drive_cycle("no_load", 1'b1, 1'b0, 1'b0, 3'd4, 3'd4, 3'd4, 1'b1);

    // Taken branch: flush cycle, one more stall cycle, then quiet.
    drive_cycle("br_taken", 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    idle("br_flush2");
    idle("br_after");

    // Branch and hazard together: branch wins, hazard dropped.
    drive_cycle("br_lu", 1'b1, 1'b1, 1'b1, 3'd2, 3'd2, 3'd2, 1'b1);
    drive_cycle("br_lu_flush2", 1'b1, 1'b0, 1'b1, 3'd2, 3'd2, 3'd2, 1'b1);
    idle("br_lu_after");

    // Branch during a bubble is ignored; branch during FLUSH is ignored too.
    drive_cycle("lu_then_br", 1'b1, 1'b0, 1'b1, 3'd6, 3'd6, 3'd0, 1'b0);
    drive_cycle("br_in_bubble", 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    drive_cycle("br_again", 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    drive_cycle("br_in_flush", 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    idle("br_seq_after");

    // Random traffic over a small register file to provoke frequent matches.
    for (int i = 0; i < 60; i++) begin
      drive_cycle("rand", 1'b1, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    idle("rand_after");

    // Reset asserted in the middle of the FLUSH sequence.
    drive_cycle("pre_rst_br", 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    @(negedge clk);
    hz.branch_taken = 1'b0;
    #1 push_expect("in_flush");
    #1 compare_pop();
    rst_n = 1'b0;
    m_reset();
    #1 push_expect("rst_mid_flush");
    #1 compare_pop();
    @(posedge clk);
    model_step();
    drive_cycle("rst_mid_hold", 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    idle("rst_mid_release");
    idle("rst_mid_after");

    // 300 back-to-back load-use hazards: bubble counter must stick at 255.
    for (int i = 0; i < 600; i++) begin
      drive_cycle("sat_bubble", 1'b1, 1'b0, 1'b1, 3'd7, 3'd7, 3'd0, 1'b0);
    end
    idle("sat_bubble_done");
    check("bubble_cnt_sat", 32'(hz.bubble_cnt), 32'd255);

    // 260 taken branches: flush counter must stick at 255 as well.
    for (int i = 0; i < 520; i++) begin
      drive_cycle("sat_flush", 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0);
    end
    idle("sat_flush_done");
    check("flush_cnt_sat", 32'(hz.flush_cnt), 32'd255);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port id_rs, input, 3 bits: source register A of the instruction in ID.
REQ-004 SHALL have port id_rt, input, 3 bits: source register B of the instruction in ID.
REQ-005 SHALL have port id_uses_rt, input, 1 bit: 1 = the ID instruction reads id_rt.
REQ-006 SHALL have port ex_load, input, 1 bit: the EX-stage instruction is a load.
REQ-007 SHALL have port ex_rd, input, 3 bits: destination register of the EX-stage instruction.
REQ-008 SHALL have port branch_taken, input, 1 bit: a taken branch or jump resolved in EX this cycle.
REQ-009 SHALL have port stall, output, 2 bits: ID/EX stall code. 00 = none, 01 = load-use bubble, 10 = control flush, 11 = never driven.
REQ-010 SHALL have port pc_hold, output, 1 bit: freeze PC this cycle.
REQ-011 SHALL have port ifid_hold, output, 1 bit: freeze the IF/ID register this cycle.
REQ-012 SHALL have port ifid_flush, output, 1 bit: load a NOP into IF/ID at the next edge.
REQ-013 SHALL have port bubble_cnt, output, 8 bits: saturating count of load-use bubbles.
REQ-014 SHALL have port flush_cnt, output, 8 bits: saturating count of control flushes.

Function
REQ-015 SHALL define load-use hazard: ex_load=1 AND ex_rd!=0 AND (ex_rd==id_rs OR (id_uses_rt AND ex_rd==id_rt)).
REQ-016 SHALL treat register 0 as hardwired: it never creates a hazard.
REQ-017 SHALL implement FSM states IDLE, BUBBLE, FLUSH.
REQ-018 SHALL drive stall, pc_hold, ifid_hold and ifid_flush combinationally from the current state and inputs, so ID/EX samples them at the same edge.
REQ-019 SHALL, in IDLE with branch_taken=1: drive stall=10 and ifid_flush=1, then go to FLUSH.
REQ-020 SHALL, in IDLE with a hazard and branch_taken=0: drive stall=01, pc_hold=1 and ifid_hold=1, then go to BUBBLE.
REQ-021 SHALL, in IDLE with neither condition: drive all four outputs 0 and stay in IDLE.
REQ-022 SHALL, in BUBBLE: suppress hazard re-detection, because the load has moved to MEM and the bubble is in EX.
REQ-023 SHALL, in BUBBLE: drive stall=00 and release the holds; branch_taken is ignored because EX holds the bubble; then return to IDLE.
REQ-024 SHALL, in FLUSH: drive stall=10 for exactly one more cycle, so that both squashed instructions lose their write controls.
REQ-025 SHALL, in FLUSH: go to IDLE on the next edge.
REQ-026 SHALL give branch_taken priority over a load-use hazard in the same cycle; the hazard is discarded.
REQ-027 SHALL increment bubble_cnt on each IDLE->BUBBLE edge and flush_cnt on each IDLE->FLUSH edge.
REQ-028 SHALL saturate both counters at 255 with no wrap-around.
REQ-029 SHALL never drive pc_hold and ifid_flush high in the same cycle.
REQ-030 SHALL never output stall=11.

Reset
REQ-031 SHALL, while rst_n=0, force state to IDLE, counters to 0 and stall, pc_hold, ifid_hold, ifid_flush to 0, independent of clk.
REQ-032 SHALL, on reset asserted mid-BUBBLE or mid-FLUSH, abort the sequence immediately, leaving no residual stall after release.
REQ-033 SHALL, on the first rising edge after rst_n rises, evaluate the inputs from the IDLE state.

Structure
REQ-034 SHALL place the stall-code constants (NONE=00, BUBBLE=01, FLUSH=10) and the FSM state encoding in the shared pipeline package; ID/EX uses the same constants.
REQ-035 SHALL use one sub-module, sat_counter8, instantiated twice, for the counters.
REQ-036 SHALL keep hazard detection as combinational logic inside hazard_unit with no further hierarchy.

Verification
REQ-037 SHALL cover load-use: ex_load=1, ex_rd=3, id_rs=3 -> same cycle stall=01, pc_hold=1, ifid_hold=1; next cycle stall=00; bubble_cnt=1.
REQ-038 SHALL cover register 0: ex_load=1, ex_rd=0, id_rs=0 -> stall=00, no hold, bubble_cnt unchanged.
REQ-039 SHALL cover rt gating: ex_rd=5, id_rt=5, id_uses_rt=0 -> no hazard; with id_uses_rt=1 -> stall=01.
REQ-040 SHALL cover taken branch: branch_taken=1 -> stall=10 and ifid_flush=1 for that cycle, stall=10 the next cycle, then 00; flush_cnt=1.
REQ-041 SHALL cover simultaneous events: branch_taken=1 together with a load-use hazard -> stall=10, pc_hold=0, bubble_cnt unchanged.
REQ-042 SHALL cover reset and saturation: rst_n=0 in FLUSH -> outputs 0 asynchronously and no stall after release; 300 hazards -> bubble_cnt=255.
